// File: rtl/fetch_queue_stage_pkg.sv
// Shared definitions for the fetch queue stage.
//   fetch_entry_t         : default queue entry layout {pc, instr, exc, ecause, etval} at 32 bits
//   NOP_INSTR             : filler instruction carried by fetch-exception entries
//   EXC_INSTR_MISALIGNED  : cause code for a misaligned fetch target
//   cnt_width()           : width of a counter that must hold 0..depth inclusive
package fetch_queue_stage_pkg;

   localparam int unsigned PKG_XLEN = 32;

   localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
   localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;

   typedef struct packed {
      logic [PKG_XLEN-1:0] pc;
      logic [31:0]         instr;
      logic                exc;
      logic [3:0]          ecause;
      logic [PKG_XLEN-1:0] etval;
   } fetch_entry_t;

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous circular buffer holding fetched instructions.
//   clk, rst    : clock, synchronous active-low reset
//   flush       : empties the buffer; overrides push and pop in the same cycle
//   push        : write push_data at the tail (ignored when full without a pop)
//   pop         : advance the head (ignored when empty)
//   head_data   : entry at the head; only meaningful when count != 0
//   count       : number of valid entries, 0..DEPTH
module fetch_queue
   import fetch_queue_stage_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   entry_t        mem [DEPTH];
   logic [PW-1:0] head_q, tail_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_pop  = pop & (count_q != '0);
   assign do_push = push & ((count_q != FULL) | do_pop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + PW'(1);
         if (do_pop)  head_q <= head_q + PW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only observed when count says they are valid.
   always_ff @(posedge clk) begin
      if (rst && !flush && do_push) mem[tail_q] <= push_data;
   end

   assign head_data = mem[head_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_queue_stage.sv
// Decoupled instruction-fetch stage with a prefetch queue in front of decode.
//   clk, rst                     : clock, synchronous active-low reset
//   exc_*/mret_*/jump_*          : redirect requests, priority exc > mret > jump
//   imem_req_*                   : in-order pipelined fetch requests
//   imem_rsp_valid/rdata         : in-order fetch responses
//   out_*                        : queue head towards decode, valid/ready handshake
// Optional feature, macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target issues no
// fetch; instead a single exception entry is queued and fetch stalls until the next
// redirect. Without the macro, target bits [1:0] are forced to zero and the exception
// outputs are tied low.
module fetch_queue_stage
   import fetch_queue_stage_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exc_valid,
   input  logic [XLEN-1:0] exc_addr,
   input  logic            mret_valid,
   input  logic [XLEN-1:0] mret_addr,
   input  logic            jump_valid,
   input  logic [XLEN-1:0] jump_addr,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_rdata,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            out_exc,
   output logic [3:0]      out_ecause,
   output logic [XLEN-1:0] out_etval,
   input  logic            out_ready
);

   localparam int unsigned CW = cnt_width(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            exc;
      logic [3:0]      ecause;
      logic [XLEN-1:0] etval;
   } entry_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count;
   logic [CW:0]     inflight;

   logic            redirect;
   logic [XLEN-1:0] redirect_addr, target;
   logic            stall;
   logic            accept, keep, push, pop;
   entry_t          push_data, head;

   assign redirect = exc_valid | mret_valid | jump_valid;

   always_comb begin
      redirect_addr = jump_addr;
      if (exc_valid)       redirect_addr = exc_addr;
      else if (mret_valid) redirect_addr = mret_addr;
   end

`ifdef FETCH_ALIGN_CHECK_EN
   logic misaligned;
   logic err_pend_q, err_pend_d;
   logic stall_q, stall_d;

   assign target     = redirect_addr;
   assign misaligned = redirect_addr[1:0] != 2'b00;
   assign stall      = stall_q;

   always_comb begin
      err_pend_d = redirect & misaligned;
      stall_d    = redirect ? misaligned : stall_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_pend_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         err_pend_q <= err_pend_d;
         stall_q    <= stall_d;
      end
   end
`else
   logic unused_addr_bits;

   assign target           = {redirect_addr[XLEN-1:2], 2'b00};
   assign unused_addr_bits = ^redirect_addr[1:0];
   assign stall            = 1'b0;
`endif

   // Queue occupancy plus in-flight requests bounds issue, so every kept response
   // is guaranteed a free slot. Only registered state feeds this, never imem_req_ready.
   assign inflight       = {1'b0, count} + {1'b0, outstanding_q};
   assign imem_req_valid = rst & ~redirect & ~stall & (inflight < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;

   assign accept = imem_req_valid & imem_req_ready;
   assign keep   = imem_rsp_valid & (drop_q == '0) & ~redirect;

   always_comb begin
      push_data = '{pc: resp_pc_q, instr: imem_rsp_rdata, exc: 1'b0, ecause: '0, etval: '0};
      push      = keep;
`ifdef FETCH_ALIGN_CHECK_EN
      // Every response is being dropped while this entry is pending, so no conflict.
      if (err_pend_q && !redirect) begin
         push_data = '{pc: resp_pc_q, instr: NOP_INSTR, exc: 1'b1,
                       ecause: EXC_INSTR_MISALIGNED, etval: resp_pc_q};
         push      = 1'b1;
      end
`endif
   end

   assign out_valid = count != '0;
   assign pop       = out_valid & out_ready & ~redirect;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
      drop_d        = drop_q;
      if (redirect) begin
         fetch_pc_d = target;
         resp_pc_d  = target;
         // No request is accepted in a redirect cycle, so this is everything still in flight.
         drop_d     = outstanding_q - CW'(imem_rsp_valid);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (keep)   resp_pc_d  = resp_pc_q + XLEN'(4);
         if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (head),
      .count     (count)
   );

   // Head fields are masked when empty so uninitialised storage never reaches decode.
   assign out_pc    = out_valid ? head.pc    : '0;
   assign out_instr = out_valid ? head.instr : '0;

`ifdef FETCH_ALIGN_CHECK_EN
   assign out_exc    = out_valid & head.exc;
   assign out_ecause = out_valid ? head.ecause : '0;
   assign out_etval  = out_valid ? head.etval  : '0;
`else
   logic unused_head_exc;

   assign unused_head_exc = ^{head.exc, head.ecause, head.etval};
   assign out_exc         = 1'b0;
   assign out_ecause      = '0;
   assign out_etval       = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage: a behavioural in-order memory with
// configurable latency and a scoreboard of expected queue entries.
module tb_fetch_queue_stage;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic        exc_valid, mret_valid, jump_valid;
   logic [31:0] exc_addr, mret_addr, jump_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_exc;
   logic [3:0]  out_ecause;
   logic [31:0] out_etval;
   logic        out_ready;

   always #5 clk = ~clk;

   fetch_queue_stage #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .exc_valid      (exc_valid),
      .exc_addr       (exc_addr),
      .mret_valid     (mret_valid),
      .mret_addr      (mret_addr),
      .jump_valid     (jump_valid),
      .jump_addr      (jump_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_rdata (imem_rsp_rdata),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_exc        (out_exc),
      .out_ecause     (out_ecause),
      .out_etval      (out_etval),
      .out_ready      (out_ready)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        exc;
      logic [31:0] etval;
   } exp_t;

   mreq_t       mem_q[$];
   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          outs = 0;
   int          pops = 0;
   int          accepts = 0;
   bit          rdy_toggle = 0;
   bit          ordy_rand = 0;
   bit          stall = 0;
   bit          got_first = 0;
   logic [31:0] first_pc = '0;
   logic [31:0] exp_fetch = RESET_PC;
   logic [31:0] exp_target = '0;

   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: memory drives at the falling edge, DUT is sampled 1 time unit later,
   // state advances at the rising edge; returns 1 time unit after it.
   task automatic cycle();
      logic redir;
      exp_t e;
      @(negedge clk);
      if (rdy_toggle) imem_req_ready = ~imem_req_ready;
      if (ordy_rand) out_ready = 1'($urandom_range(0, 1));
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_rdata = rdata_of(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_rdata = '0;
      end
      #1;
      redir = exc_valid | mret_valid | jump_valid;
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_fetch);
      if (redir) chk("req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
      if (stall) chk("req_in_stall", {31'b0, imem_req_valid}, 32'd0);
      if (out_valid && out_ready && !redir) begin
         pops++;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL out_unexpected observed pc=%h expected no entry", out_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!got_first) begin
               first_pc  = out_pc;
               got_first = 1'b1;
            end
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
            chk("out_exc", {31'b0, out_exc}, {31'b0, e.exc});
            chk("out_ecause", {28'b0, out_ecause}, 32'd0);
            chk("out_etval", out_etval, e.etval);
         end
      end
      if (imem_req_valid && imem_req_ready) begin
         accepts++;
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
         sb.push_back('{pc: exp_fetch, instr: rdata_of(exp_fetch), exc: 1'b0, etval: '0});
         exp_fetch = exp_fetch + 32'd4;
         outs++;
      end
      if (imem_rsp_valid) begin
         void'(mem_q.pop_front());
         outs--;
      end
      chk("outstanding_bound", {31'b0, outs <= DEPTH}, 32'd1);
      if (redir) begin
         sb.delete();
         exp_fetch = exp_target;
         stall     = 1'b0;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic redirect_cycle(input bit e, input logic [31:0] ea, input bit m,
                                 input logic [31:0] ma, input bit j, input logic [31:0] ja,
                                 input logic [31:0] tgt);
      exc_valid  = e;  exc_addr  = ea;
      mret_valid = m;  mret_addr = ma;
      jump_valid = j;  jump_addr = ja;
      exp_target = tgt;
      got_first  = 1'b0;
      cycle();
      exc_valid  = 1'b0;
      mret_valid = 1'b0;
      jump_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
      chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_out_pc"}, out_pc, 32'd0);
      chk({tag, "_out_instr"}, out_instr, 32'd0);
      chk({tag, "_out_exc"}, {31'b0, out_exc}, 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      exc_valid = 1'b0;  exc_addr = '0;
      mret_valid = 1'b0; mret_addr = '0;
      jump_valid = 1'b0; jump_addr = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_rdata = '0;
      out_ready = 1'b0;

      // Reset state
      run(2);
      check_reset_outputs("reset");
      rst = 1'b1;
      out_ready = 1'b1;

      // Streaming fetch from RESET_PC with single-cycle memory
      got_first = 1'b0;
      pops = 0;
      run(20);
      chk("stream_first_pc", first_pc, RESET_PC);
      chk("stream_throughput", {31'b0, pops >= 12}, 32'd1);

      // Full queue back-pressure: exactly DEPTH requests, then resume
      imem_req_ready = 1'b0;
      run(8);
      imem_req_ready = 1'b1;
      out_ready = 1'b0;
      accepts = 0;
      run(12);
      chk("full_accepts", accepts, DEPTH);
      chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
      out_ready = 1'b1;
      pops = 0;
      accepts = 0;
      run(4);
      chk("release_pops", pops, DEPTH);
      chk("release_resume", {31'b0, accepts > 0}, 32'd1);

      // Jump with two requests in flight at 3-cycle latency
      imem_req_ready = 1'b0;
      run(8);
      lat = 3;
      imem_req_ready = 1'b1;
      accepts = 0;
      run(2);
      chk("jump_inflight", accepts, 2);
      redirect_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h200, 32'h200);
      run(15);
      chk("jump_first_pc", first_pc, 32'h200);

      // exc and jump together: exception target wins
      redirect_cycle(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h400, 32'h80);
      run(12);
      chk("prio_first_pc", first_pc, 32'h80);

      // Request-ready toggling with random decode back-pressure
      lat = 2;
      rdy_toggle = 1'b1;
      ordy_rand = 1'b1;
      pops = 0;
      run(60);
      chk("toggle_progress", {31'b0, pops > 0}, 32'd1);
      rdy_toggle = 1'b0;
      ordy_rand = 1'b0;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      lat = 1;
      run(6);

      // Misaligned mret target
`ifdef FETCH_ALIGN_CHECK_EN
      pops = 0;
      redirect_cycle(1'b0, 32'h0, 1'b1, 32'h202, 1'b0, 32'h0, 32'h202);
      sb.push_back('{pc: 32'h202, instr: 32'h0000_0013, exc: 1'b1, etval: 32'h202});
      stall = 1'b1;
      run(10);
      chk("misalign_pops", pops, 1);
      chk("misalign_first_pc", first_pc, 32'h202);
      redirect_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300, 32'h300);
      run(10);
      chk("misalign_resume_pc", first_pc, 32'h300);
`else
      redirect_cycle(1'b0, 32'h0, 1'b1, 32'h202, 1'b0, 32'h0, 32'h200);
      run(10);
      chk("mret_aligned_pc", first_pc, 32'h200);
`endif

      // Reset in the middle of operation
      out_ready = 1'b0;
      rst = 1'b0;
      mem_q.delete();
      sb.delete();
      outs = 0;
      exp_fetch = RESET_PC;
      stall = 1'b0;
      run(2);
      check_reset_outputs("midreset");
      rst = 1'b1;
      out_ready = 1'b1;
      got_first = 1'b0;
      run(10);
      chk("midreset_first_pc", first_pc, RESET_PC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Parametrised, decoupled instruction-fetch stage with a prefetch queue between instruction memory and decode.
- Issues pipelined in-order fetch requests, buffers up to DEPTH returned instructions, and presents them to decode over a valid/ready handshake.
- Resolves redirects from the CSR unit (exception, mret) and from decode (jump). On a redirect it flushes the queue and discards in-flight responses.

Parameters:
- XLEN, 32, address/PC width
- DEPTH, 4, queue entries (power of 2, >=2); also bounds outstanding requests
- RESET_PC, 0, PC loaded at reset

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- exc_valid  in  1  CSR exception redirect
- exc_addr  in  XLEN  mtvec target
- mret_valid  in  1  CSR mret redirect
- mret_addr  in  XLEN  mepc target
- jump_valid  in  1  decode jump redirect
- jump_addr  in  XLEN  jump target
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  XLEN  fetch address
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response valid (in order)
- imem_rsp_rdata  in  32  instruction word
- out_valid  out  1  queue head valid
- out_pc  out  XLEN  head PC
- out_instr  out  32  head instruction
- out_exc  out  1  head carries fetch exception
- out_ecause  out  4  exception cause
- out_etval  out  XLEN  exception value
- out_ready  in  1  decode consumes head

Behaviour:
- Reset (rst=0 at a clk edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop=0.
  - All outputs 0, except imem_req_addr=RESET_PC.
- Redirect priority: exc > mret > jump. The selected target is redirect_addr. redirect = any of the three valid.
- Request issue:
  - imem_req_valid = ~redirect & (count+outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - Accepted on imem_req_valid & imem_req_ready: fetch_pc += 4 (wraps modulo 2^XLEN); outstanding +1.
  - No combinational path from imem_req_ready to imem_req_valid.
- Response handling:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise push {pc_tag, rdata, exc=0}. pc_tag comes from a resp_pc register that increments by 4 per kept response and is reloaded on redirect.
  - The space check guarantees the push never overflows.
- Output:
  - Head presented combinationally from queue storage.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop: count unchanged.
  - Push into an empty queue is visible the next cycle; there is no bypass, so fetch-to-decode latency is 1 cycle after the response.
- Redirect cycle:
  - Queue flushed, so out_valid=0 next cycle and a pop in this cycle is ignored.
  - fetch_pc=redirect_addr and resp_pc=redirect_addr.
  - drop = outstanding after this cycle's updates (outstanding minus any response arriving this cycle).
  - No request is issued in this cycle. The first request to the target goes out in the following cycle.
- Back-to-back redirects: the later one wins, and drop accumulates correctly.
- Response plus redirect in the same cycle: that response is discarded.
- Full queue with out_ready=0: no requests issued, no data lost.
- Counters: count is log2(DEPTH)+1 bits; outstanding and drop each the same width.
- Reset mid-operation clears everything. Responses that arrive after reset for pre-reset requests are the memory's responsibility; the memory interface is reset concurrently.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN
- Enabled:
  - A redirect target with addr[1:0]!=0 issues no memory request.
  - After the flush, one entry {pc=target, instr=NOP 0x00000013, exc=1, ecause=0, etval=target} is pushed.
  - Fetching then stalls (no requests) until the next redirect.
- Disabled:
  - Target addr[1:0] forced to 0.
  - out_exc, out_ecause and out_etval are tied to 0.

Decomposition:
- Shared constants package: fetch queue entry struct {pc, instr, exc, ecause, etval}, nop encoding, cause code EXC_INSTR_MISALIGNED=0.
- Sub-module fetch_queue: synchronous circular buffer with head/tail pointers, push/pop/flush, count output, parametrised by DEPTH and entry type.

Test Plan:
- Reset RESET_PC=0x100, memory always ready, 1-cycle response, out_ready=1 -> requests at 0x100, 0x104, 0x108…; out_pc sequence matches with rdata.
- out_ready=0 with DEPTH=4 -> exactly 4 requests issued then imem_req_valid=0. Release out_ready -> 4 pops in order, then issuing resumes.
- Memory latency 3 cycles, jump_valid to 0x200 while 2 requests are outstanding -> both responses dropped; first out_pc=0x200.
- exc_valid (mtvec 0x80) and jump_valid (0x400) in the same cycle -> fetch resumes at 0x80.
- imem_req_ready toggling 1/0 -> addresses stay strictly sequential with no duplicates or skips; outstanding never exceeds DEPTH.
- With FETCH_ALIGN_CHECK_EN, mret to 0x202 -> single entry with out_exc=1, out_ecause=0, out_etval=0x202, then no requests. Without the macro -> fetch at 0x200.
